// File: rtl/neuron_learn_layer_seq_pkg.sv
// Shared types, constants and saturation helpers for the learning layer.
package neuron_learn_layer_seq_pkg;

    typedef logic [7:0]         zero2one_t;  // unsigned, value/256
    typedef logic signed [15:0] frac_t;      // signed Q8.8

    localparam frac_t FRAC_MIN = 16'sh8000;
    localparam frac_t FRAC_MAX = 16'sh7fff;
    localparam frac_t W_INIT   = 16'sh0010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_LEARN,
        ST_DONE
    } state_t;

    function automatic frac_t sat_frac(input logic signed [39:0] v);
        if (v > 40'sd32767) return FRAC_MAX;
        if (v < -40'sd32768) return FRAC_MIN;
        return v[15:0];
    endfunction

    function automatic zero2one_t clamp_z2o(input logic signed [39:0] v);
        if (v < 40'sd0) return 8'd0;
        if (v > 40'sd255) return 8'd255;
        return v[7:0];
    endfunction

endpackage

// File: rtl/neuron_learn_layer_seq_mac.sv
// Signed multiply/shift/saturate datapath shared by the forward and learning passes.
module neuron_mac
    import neuron_learn_layer_seq_pkg::*;
#(
    parameter int LR_SHIFT = 4
) (
    input  logic signed [15:0] w,
    input  logic        [7:0]  x,
    input  logic signed [8:0]  err,
    input  logic signed [31:0] acc,
    output logic signed [31:0] acc_next,
    output logic signed [15:0] act,
    output logic signed [15:0] w_next,
    output logic signed [23:0] s_inc
);

    logic signed [8:0]  x_s;
    logic signed [31:0] prod_wx;
    logic signed [17:0] prod_ex;
    logic signed [24:0] prod_ew;

    assign x_s     = $signed({1'b0, x});
    assign prod_wx = 32'(w) * 32'(x_s);
    assign prod_ex = 18'(err) * 18'(x_s);
    assign prod_ew = 25'(err) * 25'(w);

    assign acc_next = acc + prod_wx;
    assign act      = sat_frac(40'(acc) >>> 8);
    // All shifts are arithmetic, so negative corrections round toward minus infinity.
    assign w_next   = sat_frac(40'(w) + 40'(prod_ex >>> (8 + LR_SHIFT)));
    assign s_inc    = 24'(prod_ew >>> 8);

endmodule

// File: rtl/neuron_learn_layer_seq.sv
// Sequential single-layer neuron array: one shared MAC runs the forward pass, then an optional weight update.
module neuron_learn_layer_seq
    import neuron_learn_layer_seq_pkg::*;
#(
    parameter int N        = 16,
    parameter int M        = 23,
    parameter int LR_SHIFT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              learn,
    input  logic [N*8-1:0]    in,
    input  logic [M*8-1:0]    expected_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M*8-1:0]    out,
    output logic [N*8-1:0]    expected_in,
    output logic [M*N*16-1:0] weights,
    output logic [M*16-1:0]   activation_max,
    output logic [M*16-1:0]   activation_min,
    output logic [1:0]        dbg_state
);

    localparam int RECIP_M = (65536 + M / 2) / M;
    localparam int NB = (N > 1) ? $clog2(N) : 1;
    localparam int MB = (M > 1) ? $clog2(M) : 1;
    localparam logic [NB-1:0] N_LAST = NB'(N - 1);
    localparam logic [MB-1:0] M_LAST = MB'(M - 1);

    state_t             state;
    logic [NB-1:0]      n_idx;
    logic [MB-1:0]      m_idx;
    logic               act_phase;
    logic               learn_q;
    logic signed [31:0] acc;
    logic signed [23:0] s_acc;
    logic [7:0]         x_q   [N];
    logic [7:0]         ein_q [N];
    logic [7:0]         t_q   [M];
    logic [7:0]         out_q [M];
    logic signed [15:0] w_q   [M][N];
    logic signed [15:0] amax_q [M];
    logic signed [15:0] amin_q [M];

    logic signed [8:0]  mac_err;
    logic signed [31:0] acc_next;
    logic signed [15:0] act;
    logic signed [15:0] w_next;
    logic signed [23:0] s_inc;
    logic signed [23:0] s_tot;
    logic signed [39:0] back_prop;
    logic [7:0]         ein_new;

    assign mac_err   = $signed({1'b0, t_q[m_idx]}) - $signed({1'b0, out_q[m_idx]});
    assign s_tot     = s_acc + s_inc;
    assign back_prop = (40'(s_tot) * 40'(RECIP_M)) >>> 16;
    assign ein_new   = clamp_z2o(40'($signed({1'b0, x_q[n_idx]})) + back_prop);
    assign dbg_state = state;

    neuron_mac #(.LR_SHIFT(LR_SHIFT)) u_mac (
        .w        (w_q[m_idx][n_idx]),
        .x        (x_q[n_idx]),
        .err      (mac_err),
        .acc      (acc),
        .acc_next (acc_next),
        .act      (act),
        .w_next   (w_next),
        .s_inc    (s_inc)
    );

    for (genvar gm = 0; gm < M; gm++) begin : g_m
        assign out[gm*8 +: 8]             = out_q[gm];
        assign activation_max[gm*16 +: 16] = amax_q[gm];
        assign activation_min[gm*16 +: 16] = amin_q[gm];
        for (genvar gn = 0; gn < N; gn++) begin : g_n
            assign weights[(gm*N+gn)*16 +: 16] = w_q[gm][gn];
        end
    end
    for (genvar gn = 0; gn < N; gn++) begin : g_ein
        assign expected_in[gn*8 +: 8] = ein_q[gn];
    end

    // Handshake: a sample moves on in_valid&&in_ready (IDLE only), a result on out_valid&&out_ready (DONE only).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            n_idx     <= '0;
            m_idx     <= '0;
            act_phase <= 1'b0;
            learn_q   <= 1'b0;
            acc       <= '0;
            s_acc     <= '0;
            for (int n = 0; n < N; n++) begin
                x_q[n]   <= '0;
                ein_q[n] <= '0;
            end
            for (int m = 0; m < M; m++) begin
                t_q[m]    <= '0;
                out_q[m]  <= '0;
                amax_q[m] <= FRAC_MIN;
                amin_q[m] <= FRAC_MAX;
                for (int n = 0; n < N; n++) w_q[m][n] <= W_INIT;
            end
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    for (int n = 0; n < N; n++) x_q[n] <= in[n*8 +: 8];
                    for (int m = 0; m < M; m++) t_q[m] <= expected_out[m*8 +: 8];
                    learn_q   <= learn;
                    n_idx     <= '0;
                    m_idx     <= '0;
                    act_phase <= 1'b0;
                    acc       <= '0;
                    state     <= ST_FWD;
                    in_ready  <= 1'b0;
                end
                ST_FWD: if (!act_phase) begin
                    acc <= acc_next;
                    if (n_idx == N_LAST) act_phase <= 1'b1;
                    else n_idx <= n_idx + NB'(1);
                end else begin
                    out_q[m_idx] <= clamp_z2o(40'(act));
                    if (act > amax_q[m_idx]) amax_q[m_idx] <= act;
                    if (act < amin_q[m_idx]) amin_q[m_idx] <= act;
                    acc       <= '0;
                    act_phase <= 1'b0;
                    n_idx     <= '0;
                    if (m_idx == M_LAST) begin
                        m_idx <= '0;
                        if (learn_q) begin
                            state <= ST_LEARN;
                        end else begin
                            for (int n = 0; n < N; n++) ein_q[n] <= x_q[n];
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        m_idx <= m_idx + MB'(1);
                    end
                end
                // Input-major walk so each input's back-propagated sum closes on its last neuron.
                ST_LEARN: begin
                    w_q[m_idx][n_idx] <= w_next;
                    if (m_idx == M_LAST) begin
                        s_acc        <= '0;
                        ein_q[n_idx] <= ein_new;
                        m_idx        <= '0;
                        if (n_idx == N_LAST) begin
                            n_idx     <= '0;
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            n_idx <= n_idx + NB'(1);
                        end
                    end else begin
                        s_acc <= s_tot;
                        m_idx <= m_idx + MB'(1);
                    end
                end
                ST_DONE: if (out_ready) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed and randomized checks of neuron_learn_layer_seq against an arithmetic reference model.
module tb_neuron_learn_layer_seq;

  localparam int N = 16;
  localparam int M = 23;
  localparam int LR_SHIFT = 4;

  logic clock = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, learn, out_valid, out_ready;
  logic [N*8-1:0] in_bus, ein_bus;
  logic [M*8-1:0] eo_bus, out_bus;
  logic [M*N*16-1:0] w_bus;
  logic [M*16-1:0] amax_bus, amin_bus;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [255:0] exp_q[$];

  int mw[M][N];
  int mmax[M];
  int mmin[M];
  int cur_x[N];
  int cur_t[M];
  bit cur_learn;
  int recip_m;

  neuron_learn_layer_seq #(.N(N), .M(M), .LR_SHIFT(LR_SHIFT)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .learn(learn),
    .in(in_bus), .expected_out(eo_bus),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out_bus), .expected_in(ein_bus), .weights(w_bus),
    .activation_max(amax_bus), .activation_min(amin_bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint clamp8(input longint v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      mmax[m] = -32768;
      mmin[m] = 32767;
      for (int n = 0; n < N; n++) mw[m][n] = 16;
    end
  endtask

  task automatic model_sample();
    int o[M];
    longint s[N];
    longint acc;
    longint a;
    int err;
    logic [255:0] ov, ev;
    ov = '0;
    ev = '0;
    for (int m = 0; m < M; m++) begin
      acc = 0;
      for (int n = 0; n < N; n++) acc += longint'(mw[m][n]) * cur_x[n];
      a = sat16(acc >>> 8);
      o[m] = int'(clamp8(a));
      if (a > mmax[m]) mmax[m] = int'(a);
      if (a < mmin[m]) mmin[m] = int'(a);
      ov[m*8 +: 8] = 8'(o[m]);
    end
    for (int n = 0; n < N; n++) begin
      s[n] = 0;
      ev[n*8 +: 8] = 8'(cur_x[n]);
    end
    if (cur_learn) begin
      for (int m = 0; m < M; m++) begin
        err = cur_t[m] - o[m];
        for (int n = 0; n < N; n++) begin
          s[n] += (longint'(err) * mw[m][n]) >>> 8;
          mw[m][n] = int'(sat16(mw[m][n] + ((longint'(err) * cur_x[n]) >>> (8 + LR_SHIFT))));
        end
      end
      for (int n = 0; n < N; n++)
        ev[n*8 +: 8] = 8'(clamp8(cur_x[n] + ((s[n] * recip_m) >>> 16)));
    end
    exp_q.push_back(ov);
    exp_q.push_back(ev);
  endtask

  function automatic int w_bad();
    int c = 0;
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        if ($signed(w_bus[(m*N+n)*16 +: 16]) != mw[m][n]) c++;
    return c;
  endfunction

  function automatic int act_bad();
    int c = 0;
    for (int m = 0; m < M; m++) begin
      if ($signed(amax_bus[m*16 +: 16]) != mmax[m]) c++;
      if ($signed(amin_bus[m*16 +: 16]) != mmin[m]) c++;
    end
    return c;
  endfunction

  function automatic int count_w(input int v);
    int c = 0;
    for (int i = 0; i < M*N; i++)
      if ($signed(w_bus[i*16 +: 16]) == v) c++;
    return c;
  endfunction

  function automatic int count_neg_w();
    int c = 0;
    for (int i = 0; i < M*N; i++)
      if ($signed(w_bus[i*16 +: 16]) < 0) c++;
    return c;
  endfunction

  function automatic int count_act(input bit use_max, input int v);
    int c = 0;
    for (int m = 0; m < M; m++)
      if ($signed(use_max ? amax_bus[m*16 +: 16] : amin_bus[m*16 +: 16]) == v) c++;
    return c;
  endfunction

  // drivers
  task automatic drive_idle();
    in_valid = 1'b0;
    learn = 1'b0;
    out_ready = 1'b0;
    in_bus = '0;
    eo_bus = '0;
  endtask

  task automatic drive_sample();
    for (int n = 0; n < N; n++) in_bus[n*8 +: 8] = 8'(cur_x[n]);
    for (int m = 0; m < M; m++) eo_bus[m*8 +: 8] = 8'(cur_t[m]);
    learn = cur_learn;
    in_valid = 1'b1;
  endtask

  task automatic scramble_inputs();
    for (int n = 0; n < N; n++) in_bus[n*8 +: 8] = 8'($urandom_range(0, 255));
    for (int m = 0; m < M; m++) eo_bus[m*8 +: 8] = 8'($urandom_range(0, 255));
    learn = 1'($urandom_range(0, 1));
  endtask

  task automatic randomize_sample(input bit lrn);
    for (int n = 0; n < N; n++) cur_x[n] = $urandom_range(0, 255);
    for (int m = 0; m < M; m++) cur_t[m] = $urandom_range(0, 255);
    cur_learn = lrn;
  endtask

  task automatic run_sample(input string tag, input bit hold);
    logic [255:0] eo, ei;
    int edges;
    int exp_lat;
    @(negedge clock);
    drive_sample();
    chk({tag, "_in_ready_idle"}, 256'(in_ready), 256'(1));
    @(posedge clock);
    model_sample();
    @(negedge clock);
    // in_valid stays high with junk data: it must be ignored until IDLE
    scramble_inputs();
    edges = 0;
    while (!out_valid && edges < 4000) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (edges == 20) chk({tag, "_in_ready_busy"}, 256'(in_ready), 256'(0));
    end
    // the accept cycle is cycle 0, so out_valid is seen in cycle edges+1
    exp_lat = M*(N+1) + 1 + (cur_learn ? M*N : 0);
    chk({tag, "_latency"}, 256'(edges + 1), 256'(exp_lat));
    eo = exp_q.pop_front();
    ei = exp_q.pop_front();
    chk({tag, "_out"}, 256'(out_bus), eo);
    chk({tag, "_ein"}, 256'(ein_bus), ei);
    chk({tag, "_w_bad"}, 256'(w_bad()), 256'(0));
    chk({tag, "_act_bad"}, 256'(act_bad()), 256'(0));
    if (hold) begin
      repeat (10) begin
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_hold_out"}, 256'(out_bus), eo);
        chk({tag, "_hold_ein"}, 256'(ein_bus), ei);
        chk({tag, "_hold_in_ready"}, 256'(in_ready), 256'(0));
        chk({tag, "_hold_out_valid"}, 256'(out_valid), 256'(1));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, "_drain_out_valid"}, 256'(out_valid), 256'(0));
    chk({tag, "_drain_in_ready"}, 256'(in_ready), 256'(1));
  endtask

  initial begin
    recip_m = $rtoi(65536.0 / M + 0.5);
    drive_idle();
    apply_reset();
    model_reset();

    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_in_ready", 256'(in_ready), 256'(1));
    chk("reset_out", 256'(out_bus), 256'(0));
    chk("reset_ein", 256'(ein_bus), 256'(0));
    chk("reset_w_init", 256'(count_w(16)), 256'(M*N));
    chk("reset_act_bad", 256'(act_bad()), 256'(0));

    // full-scale forward pass, no learning
    for (int n = 0; n < N; n++) cur_x[n] = 255;
    for (int m = 0; m < M; m++) cur_t[m] = $urandom_range(0, 255);
    cur_learn = 1'b0;
    run_sample("fwd255", 1'b0);
    chk("fwd255_out_const", 256'(out_bus), 256'({M{8'hFF}}));
    chk("fwd255_ein_const", 256'(ein_bus), 256'({N{8'hFF}}));
    chk("fwd255_w_const", 256'(count_w(16)), 256'(M*N));

    // learn toward zero targets
    for (int m = 0; m < M; m++) cur_t[m] = 0;
    cur_learn = 1'b1;
    run_sample("learn0", 1'b0);
    chk("learn0_ein_const", 256'(ein_bus), 256'({N{8'd239}}));
    chk("learn0_w_const", 256'(count_w(0)), 256'(M*N));

    // forward with the cleared weights, result held in DONE
    cur_learn = 1'b0;
    run_sample("fwd_after", 1'b1);
    chk("fwd_after_out_const", 256'(out_bus), 256'(0));
    chk("fwd_after_amin_0", 256'(count_act(1'b0, 0)), 256'(M));
    chk("fwd_after_amax_255", 256'(count_act(1'b1, 255)), 256'(M));

    for (int k = 0; k < 6; k++) begin
      randomize_sample(1'($urandom_range(0, 1)));
      run_sample($sformatf("rand%0d", k), 1'($urandom_range(0, 1)));
    end

    // reset 100 cycles into the learning pass
    randomize_sample(1'b1);
    @(negedge clock);
    drive_sample();
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (M*(N+1) + 100) @(posedge clock);
    #2;
    chk("midlearn_busy_out_valid", 256'(out_valid), 256'(0));
    chk("midlearn_busy_in_ready", 256'(in_ready), 256'(0));
    reset_n = 1'b0;
    #1;
    chk("midlearn_async_w_init", 256'(count_w(16)), 256'(M*N));
    chk("midlearn_async_out_valid", 256'(out_valid), 256'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    model_reset();
    chk("midlearn_rel_in_ready", 256'(in_ready), 256'(1));
    chk("midlearn_rel_out_valid", 256'(out_valid), 256'(0));
    chk("midlearn_rel_w_bad", 256'(w_bad()), 256'(0));
    chk("midlearn_rel_act_bad", 256'(act_bad()), 256'(0));
    chk("midlearn_rel_out", 256'(out_bus), 256'(0));

    randomize_sample(1'b1);
    run_sample("post_rst", 1'b0);

    // repeated learning toward full-scale targets: weights climb and must never wrap
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < N; n++) cur_x[n] = 64;
      for (int m = 0; m < M; m++) cur_t[m] = 255;
      cur_learn = 1'b1;
      run_sample($sformatf("grow%0d", k), 1'b0);
      chk($sformatf("grow%0d_no_neg_w", k), 256'(count_neg_w()), 256'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
